// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci generator and its inverse (index finder).
// Sequence convention: F(0)=1, F(1)=1, F(n)=F(n-1)+F(n-2).
package fib_pkg;

   localparam int unsigned FIB_WIDTH     = 16;
   localparam int unsigned FIB_IDX_WIDTH = 12;
   localparam int unsigned FIB_MAX_TERM  = 46368;
   localparam int unsigned FIB_MAX_INDEX = 23;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/fib_step_unit.sv
// Fibonacci stepper: holds the (a, b) pair and the step count.
// load restarts at (0, 1, 0); advance moves one term forward.
module fib_step_unit
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH     = FIB_WIDTH,
   parameter int unsigned IDX_WIDTH = FIB_IDX_WIDTH
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic                 load,
   input  logic                 advance,
   output logic [WIDTH:0]       a,
   output logic [WIDTH:0]       b,
   output logic [IDX_WIDTH-1:0] cnt
);

   logic [WIDTH:0] sum_c;

   assign sum_c = a + b;

   always_ff @(posedge CLK) begin
      if (reset || load) begin
         a   <= '0;
         b   <= (WIDTH+1)'(1);
         cnt <= '0;
      end else if (advance) begin
         a   <= b;
         b   <= sum_c;
         cnt <= cnt + IDX_WIDTH'(1);
      end
   end

endmodule

// File: rtl/fib_index_finder.sv
// Inverse Fibonacci: finds the smallest k with F(k) >= value.
// Defining FIBINV_REM_EN adds the rem output (value minus the largest term below it).
module fib_index_finder
   import fib_pkg::*;
#(
   parameter int unsigned WIDTH     = FIB_WIDTH,
   parameter int unsigned IDX_WIDTH = FIB_IDX_WIDTH
) (
   input  logic                 CLK,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     value,
   input  logic                 start,
   output logic                 busy,
   output logic                 done,
   output logic [IDX_WIDTH-1:0] index,
   output logic                 is_fib,
   output logic [WIDTH-1:0]     fib_ceil,
   output logic                 over
`ifdef FIBINV_REM_EN
   ,
   output logic [WIDTH-1:0]     rem
`endif
);

   state_t               state_q;
   state_t               state_d;
   logic [WIDTH-1:0]     target;
   logic                 load;
   logic                 advance;
   logic                 capture;
   logic                 hit;
   logic [WIDTH:0]       a;
   logic [WIDTH:0]       b;
   logic [IDX_WIDTH-1:0] cnt;

   fib_step_unit #(
      .WIDTH     (WIDTH),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_step (
      .CLK     (CLK),
      .reset   (reset),
      .load    (load),
      .advance (advance),
      .a       (a),
      .b       (b),
      .cnt     (cnt)
   );

   assign hit = (b >= {1'b0, target});

   // State register
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state and datapath controls; start is only honoured outside RUN
   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      advance = 1'b0;
      capture = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               load    = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (hit) begin
               capture = 1'b1;
               state_d = DONE;
            end else begin
               advance = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         target <= '0;
      end else if (load) begin
         target <= value;
      end
   end

   // Registered status and result capture on entry to DONE
   always_ff @(posedge CLK) begin
      if (reset) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         index    <= '0;
         is_fib   <= 1'b0;
         fib_ceil <= '0;
         over     <= 1'b0;
      end else begin
         busy <= (state_d == RUN);
         done <= (state_d == DONE);
         if (capture) begin
            index    <= cnt;
            is_fib   <= (b == {1'b0, target});
            fib_ceil <= b[WIDTH-1:0];
            over     <= b[WIDTH];
         end
      end
   end

`ifdef FIBINV_REM_EN
   // a never exceeds the largest WIDTH-bit term, so its low bits are exact
   always_ff @(posedge CLK) begin
      if (reset) begin
         rem <= '0;
      end else if (capture) begin
         if (b == {1'b0, target}) begin
            rem <= '0;
         end else begin
            rem <= WIDTH'(target - a[WIDTH-1:0]);
         end
      end
   end
`endif

endmodule

// File: tb/tb_fib_index_finder.sv
// Scoreboard bench for fib_index_finder: stimulus pushes expected results,
// a negedge monitor pops and compares on each rising edge of done.
module tb_fib_index_finder;

   typedef struct {
      logic [15:0] value;
      logic [11:0] index;
      logic        is_fib;
      logic [15:0] ceil;
      logic        over;
      logic [15:0] rem;
   } exp_t;

   logic        CLK;
   logic        reset;
   logic [15:0] value;
   logic        start;
   logic        busy;
   logic        done;
   logic [11:0] index;
   logic        is_fib;
   logic [15:0] fib_ceil;
   logic        over;
`ifdef FIBINV_REM_EN
   logic [15:0] rem;
`endif

   int   tests  = 0;
   int   failed = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic done_q = 1'b0;

   fib_index_finder dut (
      .CLK      (CLK),
      .reset    (reset),
      .value    (value),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .index    (index),
      .is_fib   (is_fib),
      .fib_ceil (fib_ceil),
      .over     (over)
`ifdef FIBINV_REM_EN
      ,
      .rem      (rem)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         failed++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Monitor: compare the captured result whenever done rises
   always @(negedge CLK) begin
      if (!reset && done && !done_q) begin
         if (sb.size() == 0) begin
            tests++;
            failed++;
            $display("FAIL unexpected_done: index=%0d with empty scoreboard", index);
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("index v=%0d", mon_e.value), int'(index), int'(mon_e.index));
            chk($sformatf("is_fib v=%0d", mon_e.value), int'(is_fib), int'(mon_e.is_fib));
            chk($sformatf("fib_ceil v=%0d", mon_e.value), int'(fib_ceil), int'(mon_e.ceil));
            chk($sformatf("over v=%0d", mon_e.value), int'(over), int'(mon_e.over));
`ifdef FIBINV_REM_EN
            chk($sformatf("rem v=%0d", mon_e.value), int'(rem), int'(mon_e.rem));
`endif
         end
      end
      done_q = done;
   end

   // Issue one request; start is driven at negedge so the next posedge is E0
   task automatic run_vec(input logic [15:0] v, input int k, input logic fib,
                          input logic [15:0] ceil, input logic ov,
                          input logic [15:0] r, input bit noise);
      int n;
      sb.push_back('{v, 12'(k), fib, ceil, ov, r});
      value = v;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk($sformatf("busy_after_E0 v=%0d", v), int'(busy), 1);
      chk($sformatf("done_after_E0 v=%0d", v), int'(done), 0);
      n = 0;
      while (!done && n < 200) begin
         if (noise && n < 6) begin
            start = n[0];
            value = 16'd2;
         end else begin
            start = 1'b0;
         end
         @(negedge CLK);
         n++;
      end
      start = 1'b0;
      chk($sformatf("latency v=%0d", v), n, k + 1);
      chk($sformatf("busy_in_done v=%0d", v), int'(busy), 0);
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " busy"}, int'(busy), 0);
      chk({tag, " done"}, int'(done), 0);
      chk({tag, " index"}, int'(index), 0);
      chk({tag, " is_fib"}, int'(is_fib), 0);
      chk({tag, " fib_ceil"}, int'(fib_ceil), 0);
      chk({tag, " over"}, int'(over), 0);
`ifdef FIBINV_REM_EN
      chk({tag, " rem"}, int'(rem), 0);
`endif
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1;
      start = 1'b0;
      value = 16'd0;
      repeat (3) @(negedge CLK);
      chk_cleared("reset");
      // start together with reset: reset must win
      start = 1'b1;
      value = 16'd13;
      @(negedge CLK);
      reset = 1'b0;
      start = 1'b0;
      @(negedge CLK);
      chk("start_during_reset busy", int'(busy), 0);
      chk("start_during_reset done", int'(done), 0);

      //       value    k   fib  ceil     over  rem    noise
      run_vec(16'd13,    6, 1'b1, 16'd13,    1'b0, 16'd0,     1'b0);
      run_vec(16'd4,     4, 1'b0, 16'd5,     1'b0, 16'd1,     1'b0);
      run_vec(16'd0,     0, 1'b0, 16'd1,     1'b0, 16'd0,     1'b0);
      run_vec(16'd1,     0, 1'b1, 16'd1,     1'b0, 16'd0,     1'b0);
      run_vec(16'd2,     2, 1'b1, 16'd2,     1'b0, 16'd0,     1'b0);
      run_vec(16'd46368, 23, 1'b1, 16'd46368, 1'b0, 16'd0,    1'b0);
      run_vec(16'd50000, 24, 1'b0, 16'd9489,  1'b1, 16'd3632, 1'b0);
      run_vec(16'd65535, 24, 1'b0, 16'd9489,  1'b1, 16'd19167, 1'b0);
      run_vec(16'd89,    10, 1'b1, 16'd89,    1'b0, 16'd0,    1'b1);

      // Abort a long run with reset on its 5th RUN cycle
      value = 16'd1000;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (4) @(negedge CLK);
      chk("pre_abort busy", int'(busy), 1);
      reset = 1'b1;
      @(negedge CLK);
      reset = 1'b0;
      chk_cleared("mid_run_reset");
      @(negedge CLK);
      chk("post_reset idle busy", int'(busy), 0);

      run_vec(16'd21,    7, 1'b1, 16'd21,    1'b0, 16'd0,     1'b0);

      repeat (3) @(negedge CLK);
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
